// File: rtl/tmds_decode.sv
`timescale 1ns/1ps
// TMDS channel receiver: finds symbol alignment by rotating the deserialized
// word until a run of blanking control tokens is seen, then decodes pixels/controls.
module tmds_decode #(
    parameter int SEARCH_WIN   = 1024,
    parameter int CTRL_RUN     = 8,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int SETTLE       = 2
) (
    input  logic       clkin,
    input  logic       rstin,
    input  logic [9:0] din,
    output logic [7:0] dout,
    output logic       c0,
    output logic       c1,
    output logic       de,
    output logic       aligned,
    output logic [3:0] rot
);
    localparam logic [15:0] SEARCH_LAST = 16'(SEARCH_WIN - 1);
    localparam logic [7:0]  RUN_LEN     = 8'(CTRL_RUN);
    localparam logic [15:0] IDLE_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]  SETTLE_LEN  = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  din_q, din_d;
    logic [9:0]  word_q, word_d;
    logic [19:0] shifted;
    logic [3:0]  rot_q, rot_d;
    logic        aligned_q, aligned_d;
    logic [15:0] search_cnt_q, search_cnt_d;
    logic [7:0]  tok_run_q, tok_run_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [7:0]  dout_q, dout_d;
    logic        c0_q, c0_d;
    logic        c1_q, c1_d;
    logic        de_q, de_d;

    logic        is_tok;
    logic [1:0]  tok_code;
    logic [7:0]  d_un;
    logic [7:0]  dec;
    logic [7:0]  tok_run_inc;

    // Two consecutive words hold every possible 10-bit symbol phase.
    always_comb begin
        din_d   = din;
        shifted = {din, din_q} >> rot_q;
        word_d  = shifted[9:0];
    end

    always_comb begin
        is_tok   = 1'b1;
        tok_code = 2'b00;
        case (word_q)
            10'b1101010100: tok_code = 2'b00;
            10'b0010101011: tok_code = 2'b01;
            10'b0101010100: tok_code = 2'b10;
            10'b1010101011: tok_code = 2'b11;
            default:        is_tok   = 1'b0;
        endcase
    end

    assign d_un   = word_q[9] ? ~word_q[7:0] : word_q[7:0];
    assign dec[0] = d_un[0];

    // Bit 8 says whether the encoder chained with XOR or XNOR.
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_dec
            assign dec[gi] = word_q[8] ? (d_un[gi] ^ d_un[gi-1])
                                       : ~(d_un[gi] ^ d_un[gi-1]);
        end
    endgenerate

    always_comb begin
        dout_d = 8'd0;
        de_d   = 1'b0;
        c0_d   = c0_q;
        c1_d   = c1_q;
        if (!aligned_q) begin
            c0_d = 1'b0;
            c1_d = 1'b0;
        end else if (is_tok) begin
            c1_d = tok_code[1];
            c0_d = tok_code[0];
        end else begin
            de_d   = 1'b1;
            dout_d = dec;
        end
    end

    always_comb begin
        state_d      = state_q;
        rot_d        = rot_q;
        aligned_d    = aligned_q;
        search_cnt_d = search_cnt_q;
        tok_run_d    = tok_run_q;
        idle_cnt_d   = idle_cnt_q;
        settle_cnt_d = settle_cnt_q;
        tok_run_inc  = (tok_run_q == 8'hFF) ? tok_run_q : tok_run_q + 8'd1;
        case (state_q)
            ST_SEARCH: begin
                search_cnt_d = (search_cnt_q == 16'hFFFF) ? search_cnt_q
                                                          : search_cnt_q + 16'd1;
                tok_run_d    = is_tok ? tok_run_inc : 8'd0;
                // A completed token run takes priority over an expiring window.
                if (is_tok && tok_run_inc >= RUN_LEN) begin
                    state_d    = ST_LOCKED;
                    aligned_d  = 1'b1;
                    idle_cnt_d = 16'd0;
                end else if (search_cnt_q >= SEARCH_LAST) begin
                    state_d = ST_SLIP;
                end
            end
            ST_SLIP: begin
                rot_d        = (rot_q >= 4'd9) ? 4'd0 : rot_q + 4'd1;
                search_cnt_d = 16'd0;
                tok_run_d    = 8'd0;
                settle_cnt_d = SETTLE_LEN;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q <= 4'd1) begin
                    settle_cnt_d = 4'd0;
                    state_d      = ST_SEARCH;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            ST_LOCKED: begin
                if (is_tok) begin
                    idle_cnt_d = 16'd0;
                end else if (idle_cnt_q >= IDLE_LAST) begin
                    aligned_d    = 1'b0;
                    state_d      = ST_SEARCH;
                    search_cnt_d = 16'd0;
                    tok_run_d    = 8'd0;
                    idle_cnt_d   = 16'd0;
                end else begin
                    idle_cnt_d = (idle_cnt_q == 16'hFFFF) ? idle_cnt_q
                                                          : idle_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            state_q      <= ST_SEARCH;
            din_q        <= 10'd0;
            word_q       <= 10'd0;
            rot_q        <= 4'd0;
            aligned_q    <= 1'b0;
            search_cnt_q <= 16'd0;
            tok_run_q    <= 8'd0;
            idle_cnt_q   <= 16'd0;
            settle_cnt_q <= 4'd0;
            dout_q       <= 8'd0;
            c0_q         <= 1'b0;
            c1_q         <= 1'b0;
            de_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            din_q        <= din_d;
            word_q       <= word_d;
            rot_q        <= rot_d;
            aligned_q    <= aligned_d;
            search_cnt_q <= search_cnt_d;
            tok_run_q    <= tok_run_d;
            idle_cnt_q   <= idle_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            dout_q       <= dout_d;
            c0_q         <= c0_d;
            c1_q         <= c1_d;
            de_q         <= de_d;
        end
    end

    assign dout    = dout_q;
    assign c0      = c0_q;
    assign c1      = c1_q;
    assign de      = de_q;
    assign aligned = aligned_q;
    assign rot     = rot_q;

endmodule
